// File: rtl/shift_unit_scheduler_if.sv
// Request/response bundle for shift_unit_scheduler.
//   req_valid[i] / req_ready[i] : per-requester request handshake
//   req_op*/req_data*/req_shamt*: opcode, operand and shift amount per requester
//   resp_valid / resp_ready     : response handshake toward the consumer
//   resp_data/resp_id/resp_err  : result, issuing requester, illegal-op flag
// master = requesters plus result consumer, slave = scheduler.
interface shift_unit_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0;
    logic [31:0] req_data0;
    logic [4:0]  req_shamt0;
    logic [2:0]  req_op1;
    logic [31:0] req_data1;
    logic [4:0]  req_shamt1;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic        resp_err;

    modport master (
        output req_valid, req_op0, req_data0, req_shamt0,
        output req_op1, req_data1, req_shamt1, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_op0, req_data0, req_shamt0,
        input  req_op1, req_data1, req_shamt1, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );
endinterface

// File: rtl/shift_unit_scheduler.sv
// Shares one external combinational 32-bit barrel shifter between two
// requesters with round-robin arbitration. Each request is decoded into
// shifter dir/feedinbit/shamt controls; rotates take two shifter passes
// whose results are OR-ed. One request is in flight at a time.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : request handshake per requester, tagged response port
//   sh_in/sh_shamt/sh_dir/sh_feedinbit : controls to the shifter
//   sh_out         : shifter result (combinational from the controls)
//   busy           : high whenever the scheduler is not idle
// Parameter ROT_EN: 1 = rotates supported, 0 = rotates flagged as errors.
module shift_unit_scheduler #(
    parameter bit ROT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_unit_scheduler_if.slave bus,
    output logic [31:0]           sh_in,
    output logic [4:0]            sh_shamt,
    output logic                  sh_dir,
    output logic                  sh_feedinbit,
    input  logic [31:0]           sh_out,
    output logic                  busy
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t      state;
    logic        rr_ptr;
    logic [2:0]  op_q;
    logic [31:0] data_q;
    logic [4:0]  shamt_q;
    logic        id_q;
    logic [31:0] acc;
    logic        resp_valid_q;
    logic        resp_err_q;

    logic        grant_vld;
    logic        grant;

    function automatic logic op_is_rot(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    function automatic logic op_is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    // Undefined encodings, and rotates when rotate support is compiled out.
    function automatic logic op_is_err(input logic [2:0] op);
        return (op > OP_ROR) || (op_is_rot(op) && !ROT_EN);
    endfunction

    // Round-robin pick: the pointed-to requester first, else the other one.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        if (bus.req_valid[rr_ptr]) begin
            grant_vld = 1'b1;
            grant     = rr_ptr;
        end else if (bus.req_valid[~rr_ptr]) begin
            grant_vld = 1'b1;
            grant     = ~rr_ptr;
        end
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (state == IDLE && grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Second rotate pass goes the other way by (32 - shamt) mod 32, which
    // is just the 5-bit two's complement of the captured amount.
    always_comb begin
        sh_in        = '0;
        sh_shamt     = '0;
        sh_dir       = 1'b0;
        sh_feedinbit = 1'b0;
        case (state)
            PASS1: begin
                sh_in        = data_q;
                sh_shamt     = shamt_q;
                sh_dir       = op_is_left(op_q);
                sh_feedinbit = (op_q == OP_SRA) & data_q[31];
            end
            PASS2: begin
                sh_in    = data_q;
                sh_shamt = 5'd0 - shamt_q;
                sh_dir   = ~op_is_left(op_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            op_q         <= '0;
            data_q       <= '0;
            shamt_q      <= '0;
            id_q         <= 1'b0;
            acc          <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_q    <= grant ? bus.req_op1    : bus.req_op0;
                        data_q  <= grant ? bus.req_data1  : bus.req_data0;
                        shamt_q <= grant ? bus.req_shamt1 : bus.req_shamt0;
                        id_q    <= grant;
                        rr_ptr  <= ~grant;
                        state   <= PASS1;
                    end
                end
                PASS1: begin
                    resp_err_q <= op_is_err(op_q);
                    acc        <= op_is_err(op_q) ? data_q : sh_out;
                    // A rotate by zero is complete after one pass.
                    if (!op_is_err(op_q) && op_is_rot(op_q) && shamt_q != 5'd0) begin
                        state <= PASS2;
                    end else begin
                        state        <= DONE;
                        resp_valid_q <= 1'b1;
                    end
                end
                PASS2: begin
                    acc          <= acc | sh_out;
                    state        <= DONE;
                    resp_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = acc;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_shift_unit_scheduler.sv
module tb_shift_unit_scheduler;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_unit_scheduler_if bus ();
    shift_unit_scheduler_if bus2 ();

    logic [31:0] sh_in, sh_out, sh_in2, sh_out2;
    logic [4:0]  sh_shamt, sh_shamt2;
    logic        sh_dir, sh_feedinbit, busy;
    logic        sh_dir2, sh_feedinbit2, busy2;

    shift_unit_scheduler #(.ROT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_dir(sh_dir),
        .sh_feedinbit(sh_feedinbit), .sh_out(sh_out), .busy(busy)
    );

    shift_unit_scheduler #(.ROT_EN(1'b0)) dut_norot (
        .clk(clk), .rst(rst), .bus(bus2),
        .sh_in(sh_in2), .sh_shamt(sh_shamt2), .sh_dir(sh_dir2),
        .sh_feedinbit(sh_feedinbit2), .sh_out(sh_out2), .busy(busy2)
    );

    // Behavioural barrel shifter: vacated bits are filled with feedinbit.
    function automatic logic [31:0] bshift(input logic [31:0] d, input logic [4:0] s,
                                           input logic dir, input logic fb);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        if (dir) return (d << s) | (fb ? ~(ones << s) : 32'h0);
        else     return (d >> s) | (fb ? ~(ones >> s) : 32'h0);
    endfunction

    assign sh_out  = bshift(sh_in, sh_shamt, sh_dir, sh_feedinbit);
    assign sh_out2 = bshift(sh_in2, sh_shamt2, sh_dir2, sh_feedinbit2);

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic        err;
        int          lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    bit   lat_seen = 1'b0;
    exp_t e;
    vec_t vecs[13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            lat_seen = 1'b0;
        end else begin
            if (bus.req_ready != 2'b00) begin
                chk("ready_onehot", $countones(bus.req_ready), 1);
                chk("ready_only_idle", {31'b0, busy}, 0);
                if ((bus.req_ready & bus.req_valid) != 2'b00) acc_q.push_back(cyc + 1);
            end
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {31'b0, bus.resp_valid}, 0);
                end else begin
                    if (!lat_seen && acc_q.size() > 0) begin
                        chk("latency", cyc + 1 - acc_q[0], exp_q[0].lat);
                        lat_seen = 1'b1;
                    end
                    if (bus.resp_ready) begin
                        e = exp_q.pop_front();
                        chk("resp_data", bus.resp_data, e.data);
                        chk("resp_id", {31'b0, bus.resp_id}, {31'b0, e.id});
                        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                        if (acc_q.size() > 0) void'(acc_q.pop_front());
                        lat_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] s);
        if (id == 1'b0) begin
            bus.req_op0 = op; bus.req_data0 = d; bus.req_shamt0 = s;
        end else begin
            bus.req_op1 = op; bus.req_data1 = d; bus.req_shamt1 = s;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    // Drive a request and return just after its accepting edge.
    task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] s, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        set_req(id, op, d, s);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                got = 1'b1;
                break;
            end
            waits++;
            tick();
        end
        if (!got) chk("accept_timeout", {31'b0, bus.req_ready[id]}, 1);
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic run_norot(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                             input logic [31:0] exp_d, input logic exp_err);
        bit got;
        bus2.req_op0    = op;
        bus2.req_data0  = d;
        bus2.req_shamt0 = s;
        bus2.req_valid  = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus2.req_ready[0]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) chk("norot_accept", {30'b0, bus2.req_ready}, 1);
        tick();
        bus2.req_valid = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus2.resp_valid) begin
                chk("norot_data", bus2.resp_data, exp_d);
                chk("norot_err", {31'b0, bus2.resp_err}, {31'b0, exp_err});
                chk("norot_id", {31'b0, bus2.resp_id}, 0);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("norot_resp_valid", {31'b0, bus2.resp_valid}, 1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int grants;

        vecs[0]  = '{1'b0, SLL,    32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 2};
        vecs[1]  = '{1'b1, SRA,    32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, 2};
        vecs[2]  = '{1'b1, SRL,    32'h8000_00F0, 5'd4,  32'h0800_000F, 1'b0, 2};
        vecs[3]  = '{1'b0, ROL,    32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 3};
        vecs[4]  = '{1'b0, ROR,    32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 3};
        vecs[5]  = '{1'b1, 3'b110, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b1, 2};
        vecs[6]  = '{1'b0, SRA,    32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 2};
        vecs[7]  = '{1'b1, ROL,    32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 2};
        vecs[8]  = '{1'b1, ROR,    32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 3};
        vecs[9]  = '{1'b0, SRA,    32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 2};
        vecs[10] = '{1'b0, 3'b101, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b1, 2};
        vecs[11] = '{1'b1, ROL,    32'h1234_5678, 5'd31, 32'h091A_2B3C, 1'b0, 3};
        vecs[12] = '{1'b0, SLL,    32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0, 2};

        bus.req_valid = 2'b00; bus.resp_ready = 1'b1;
        bus.req_op0 = '0; bus.req_data0 = '0; bus.req_shamt0 = '0;
        bus.req_op1 = '0; bus.req_data1 = '0; bus.req_shamt1 = '0;
        bus2.req_valid = 2'b00; bus2.resp_ready = 1'b1;
        bus2.req_op0 = '0; bus2.req_data0 = '0; bus2.req_shamt0 = '0;
        bus2.req_op1 = '0; bus2.req_data1 = '0; bus2.req_shamt1 = '0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_id", {31'b0, bus.resp_id}, 0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_req_ready", {30'b0, bus.req_ready}, 0);
        chk("rst_sh_in", sh_in, 0);
        chk("rst_sh_ctl", {25'b0, sh_shamt, sh_dir, sh_feedinbit}, 0);
        tick();

        // Table-driven single requests
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back('{vecs[i].exp_data, vecs[i].id, vecs[i].exp_err, vecs[i].exp_lat});
            issue(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].shamt, w);
            chk("ready_first_cycle", w, 0);
            wait_idle();
        end

        // Rotate: shifter controls for both passes
        exp_q.push_back('{32'h0000_0018, 1'b0, 1'b0, 3});
        issue(1'b0, ROL, 32'h8000_0001, 5'd4, w);
        @(negedge clk);
        chk("p1_sh_in", sh_in, 32'h8000_0001);
        chk("p1_sh_ctl", {29'b0, sh_shamt == 5'd4, sh_dir, sh_feedinbit}, 32'h6);
        chk("p1_busy", {31'b0, busy}, 1);
        tick();
        @(negedge clk);
        chk("p2_sh_shamt", {27'b0, sh_shamt}, 28);
        chk("p2_sh_dir_fb", {30'b0, sh_dir, sh_feedinbit}, 0);
        tick();
        @(negedge clk);
        chk("done_sh_idle", {sh_in[26:0], sh_shamt}, 0);
        wait_idle();

        // Response back-pressure with a pending request on the other side
        bus.resp_ready = 1'b0;
        exp_q.push_back('{32'h0000_000C, 1'b0, 1'b0, 2});
        issue(1'b0, SLL, 32'h0000_0003, 5'd2, w);
        exp_q.push_back('{32'h0000_0010, 1'b1, 1'b0, 2});
        set_req(1'b1, SRL, 32'h0000_0100, 5'd4);
        @(negedge clk);
        chk("stall_p1_ready", {30'b0, bus.req_ready}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, bus.resp_valid}, 1);
            chk("stall_data", bus.resp_data, 32'h0000_000C);
            chk("stall_busy", {31'b0, busy}, 1);
            chk("stall_ready", {30'b0, bus.req_ready}, 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_cycle_ready", {30'b0, bus.req_ready}, 0);
        tick();
        @(negedge clk);
        chk("after_handshake_ready", {30'b0, bus.req_ready}, 2);
        tick();
        bus.req_valid[1] = 1'b0;
        wait_idle();

        // Reset while a response is pending
        bus.resp_ready = 1'b0;
        exp_q.push_back('{32'h0000_000F, 1'b1, 1'b0, 2});
        issue(1'b1, SRL, 32'h0000_00F0, 5'd4, w);
        tick();
        @(negedge clk);
        chk("done_before_rst", {31'b0, bus.resp_valid}, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_valid", {31'b0, bus.resp_valid}, 0);
        chk("rst_done_busy", {31'b0, busy}, 0);
        tick();

        // Continuous contention: grants alternate starting at requester 0
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{32'h0000_0002, 1'b0, 1'b0, 2});
            exp_q.push_back('{32'h0000_0200, 1'b1, 1'b0, 2});
            k++;
        end
        set_req(1'b0, SLL, 32'h0000_0001, 5'd1);
        set_req(1'b1, SLL, 32'h0000_0100, 5'd1);
        grants = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                chk("grant_seq", {30'b0, bus.req_ready}, (grants % 2 == 0) ? 32'd1 : 32'd2);
                grants++;
                if (grants == 4) begin
                    tick();
                    bus.req_valid = 2'b00;
                    break;
                end
            end
            tick();
        end
        if (grants != 4) begin
            bus.req_valid = 2'b00;
            chk("grant_count", grants, 4);
        end
        wait_idle();

        // Reset in PASS2 aborts the rotate with no response
        issue(1'b0, ROL, 32'h0000_0001, 5'd5, w);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_pass2", {27'b0, sh_shamt}, 27);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 0);
        chk("abort_resp_data", bus.resp_data, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'b0, bus.resp_valid}, 0);
            tick();
        end

        // Rotate support compiled out
        run_norot(ROL, 32'hA5A5_0F0F, 5'd4, 32'hA5A5_0F0F, 1'b1);
        run_norot(ROR, 32'h0000_0001, 5'd1, 32'h0000_0001, 1'b1);
        run_norot(SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_unit_scheduler.md
Name: shift_unit_scheduler

Overview:
- Sequences and shares one combinational 32-bit BarrelShifter between two requesters. Typical requesters are the ALU shift path and the address/immediate formatter.
- Arbitration is round-robin. The block decodes a 3-bit shift opcode into the shifter's dir/feedinbit/shamt controls.
- Rotates are run as two shifter passes OR-ed together.
- Results return on a tagged valid/ready response port.

Parameters:
ROT_EN, 1, 1 = rotate opcodes supported; 0 = rotate opcodes return resp_err=1 and unshifted data.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  2  bit i = requester i has a request pending
req_ready  output  2  bit i = requester i's request is accepted this cycle
req_op0  input  3  requester 0 opcode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
req_data0  input  32  requester 0 operand
req_shamt0  input  5  requester 0 shift amount
req_op1  input  3  requester 1 opcode (same encoding)
req_data1  input  32  requester 1 operand
req_shamt1  input  5  requester 1 shift amount
sh_in  output  32  to shifter in
sh_shamt  output  5  to shifter shamt
sh_dir  output  1  to shifter dir (1 = left)
sh_feedinbit  output  1  to shifter feedinbit
sh_out  input  32  from shifter out (combinational)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  32  shift result
resp_id  output  1  index of the requester that issued the result
resp_err  output  1  illegal opcode (or rotate with ROT_EN=0)
busy  output  1  state != IDLE

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - state=IDLE, rr_ptr=0.
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - Captured op/data/shamt registers = 0.
  - Reset mid-operation aborts the in-flight request with no response, including a response pending in DONE.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - grant = rr_ptr's requester if its req_valid=1, else the other requester if its req_valid=1.
  - req_ready[grant]=1, combinationally. req_ready is 0 in every other state and for the non-granted requester.
  - On handshake: capture op/data/shamt/id, toggle rr_ptr to !grant, go to PASS1.
  - Requesters hold their request stable until req_ready.
- PASS1 drives the shifter with sh_in=captured data and registers sh_out into acc:
  - SLL, ROL: dir=1, feedinbit=0, shamt=captured shamt.
  - SRL, ROR: dir=0, feedinbit=0, shamt=captured shamt.
  - SRA: dir=0, feedinbit=data[31], shamt=captured shamt.
  - Illegal op, or rotate with ROT_EN=0: acc=data and resp_err=1.
  - Next state: PASS2 if the op is a rotate AND shamt!=0 AND ROT_EN=1; otherwise DONE.
- PASS2 runs the opposite direction with feedinbit=0 and shamt=(32-shamt) mod 32, the 5-bit two's complement of shamt. Registers acc | sh_out, then goes to DONE.
- Shifter controls outside PASS1/PASS2: sh_in=0, sh_shamt=0, sh_dir=0, sh_feedinbit=0.
- DONE:
  - resp_valid=1; resp_data/resp_id/resp_err are stable until resp_valid && resp_ready at a clk edge, then IDLE.
  - No new request is accepted in DONE, even on the handshake cycle. The back-to-back issue interval is therefore 3 cycles (non-rotate) or 4 (rotate).
- Latency from the accepting edge to the edge at which resp_valid is first seen high:
  - 2 cycles for SLL, SRL, SRA, illegal ops and rotate with shamt=0.
  - 3 cycles for rotates with shamt!=0.
- Simultaneous requests: rr_ptr decides. Under continuous contention, grants alternate 0,1,0,1.
- A single active requester is granted regardless of rr_ptr. rr_ptr still toggles to the non-granted index.
- The shamt width is 5 bits; values are taken mod 32 by construction. SRA with shamt 0 returns data unchanged.

Test Plan:
- Reset then req0 SLL data=0x0000_0001 shamt=31 -> req_ready=01 on the first cycle; resp_valid 2 cycles after acceptance; resp_data=0x8000_0000, resp_id=0, resp_err=0.
- req1 SRA data=0x8000_00F0 shamt=4 -> resp_data=0xF800_000F. SRL with the same operands -> 0x0800_000F.
- ROL data=0x8000_0001 shamt=4 -> pass1 sh_shamt=4 dir=1, pass2 sh_shamt=28 dir=0; resp_data=0x0000_0018 at latency 3. ROR data=0x0000_0001 shamt=1 -> 0x8000_0000.
- Both req_valid held high with SLL shamt=1, resp_ready=1 -> grant/resp_id sequence 0,1,0,1. req_ready is never high on both bits or outside IDLE.
- resp_ready=0 for 5 cycles in DONE -> resp_valid/resp_data held and busy=1. A pending req_valid is not accepted until the cycle after the response handshake.
- op=110 data=0x1234_5678 -> resp_err=1, resp_data=0x1234_5678. ROL with ROT_EN=0 -> resp_err=1. Asserting rst in PASS2 -> the next cycle is IDLE, resp_valid=0, and no response is ever issued.
